id_ex_hazard_stage: RTL
=======================

// Module: id_ex_hazard_stage
// PURPOSE
//  ID/EX pipeline register plus load-use hazard detector for the 5-stage MIPS core.
//  Captures decoded operands/control from ID each cycle and presents them to EX.
//  Its ex_rs/ex_rt outputs drive the forwarding unit's ID_Ex_Rs/ID_Ex_Rt inputs.
//  Stalls IF/ID and inserts a bubble on a load-use hazard; bubbles on branch flush.
// PARAMETERS
//  DATA_W      32  operand/immediate/PC width
//  REG_ADDR_W  5   register specifier width
//  ALU_OP_W    3   ALU control width
//  CNT_W       16  stall-counter width (saturating)
// PORTS
//  clk             in   1           rising-edge clock
//  rst             in   1           synchronous, active-high reset
//  id_rs/id_rt/id_rd in REG_ADDR_W  decoded register specifiers
//  id_uses_rs      in   1           ID instruction reads rs
//  id_uses_rt      in   1           ID instruction reads rt
//  id_ctrl_*       in   1 each      reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst
//  id_alu_op       in   ALU_OP_W    ALU control
//  id_rd1/id_rd2   in   DATA_W      register-file read data
//  id_imm          in   DATA_W      sign-extended immediate
//  id_pc4          in   DATA_W      PC+4
//  flush           in   1           branch taken/redirect: squash ID instruction
//  ex_*            out  (as above)  registered copies of all id_* fields
//  pc_write        out  1           0 = hold PC
//  if_id_write     out  1           0 = hold IF/ID register
//  load_use_stall  out  1           hazard detected this cycle
//  stall_count     out  CNT_W       stall cycles since reset, saturating
// BEHAVIOUR
//  - Hazard (combinational, from ID inputs and EX registers):
//    hz = ex_ctrl_mem_read & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt))
//  - load_use_stall = hz & ~flush. pc_write = if_id_write = ~load_use_stall.
//  - Register update each rising edge, priority order:
//    1 rst: every ex_* field = 0 (bubble); stall_count = 0.
//    2 flush: bubble (all ex_ctrl_* = 0, ex_alu_op = 0); data fields may load ID values.
//    3 hz: bubble; IF/ID + PC held via outputs; stall_count += 1 unless all-ones.
//    4 else: all ex_* <= id_*.
//  - Bubble zeroes reg_write/mem_write/mem_read, so no architectural side effects and
//    forwarding unit never matches a bubble.
//  - Latency: 1 cycle ID->EX. Stall lasts exactly 1 cycle: following cycle EX holds the
//    bubble (mem_read=0), so hz clears; load result then reaches dependent via MEM/WB forward.
//  - flush & hz same cycle: flush wins; no stall, pc_write=1, stall_count unchanged.
//  - Reset outputs: pc_write=if_id_write=1, load_use_stall=0 (EX regs zero).
//  - Reset asserted mid-stall: next cycle all regs zero, stall abandoned, no hold carries over.
//  - ex_rt==0 load (e.g. lw $0): never stalls.
// STRUCTURE
//  - Shared pipeline package: ALU_OP_W, REG_ADDR_W, DATA_W constants, ID/EX control-field
//    bundle typedef, BUBBLE control constant (all zeros).
//  - One natural sub-module: load_use_detector (pure combinational hz equation); the
//    register bank and stall counter stay in this module.
// TESTING
//  1 rst=1 two cycles with random id_* -> all ex_*=0, stall_count=0, pc_write=1.
//  2 No hazard: id_rs=3,id_rt=4,reg_write=1,rd1=0x11 -> next cycle ex_rs=3,ex_rd1=0x11, no stall.
//  3 lw $5 in EX (mem_read=1,ex_rt=5), ID add rs=5 uses_rs=1 -> load_use_stall=1, pc_write=0,
//    next cycle ex_ctrl all 0; cycle after, same add enters EX; stall_count=1.
//  4 lw $5 in EX, ID uses_rt=0 with id_rt=5 -> no stall; lw $0 in EX with id_rs=0 -> no stall.
//  5 Hazard + flush same cycle -> load_use_stall=0, pc_write=1, bubble in EX, count unchanged.
//  6 Force stall_count to all-ones via CNT_W=2 and 4 stalls -> stays 3; rst mid-stall -> regs 0.

Source files
------------

// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared pipeline definitions for the ID/EX stage: widths, control bundle, bubble constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_hazard_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 3;
    localparam int CNT_W      = 16;

    // Decoded control travelling from ID into EX.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic reg_dst;
    } ctrl_t;

    // A bubble has no write/read side effects, so the forwarding unit never matches it.
    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard_stage_detector.sv
// Load-use hazard equation: a load in EX whose destination is read by the ID instruction.
// Latency: purely combinational.
// Backpressure: none; the result feeds the stall outputs of the stage.
// Ports: ex_mem_read/ex_rt from the EX register, id_rs/id_rt/id_uses_* from ID, hz out.
module load_use_detector #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    output logic                  hz
);

    // A load into $0 produces nothing to wait for, so it never stalls.
    assign hz = ex_mem_read && (ex_rt != '0) &&
                ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall and branch-flush bubble insertion.
// Latency: 1 cycle ID->EX; stall outputs are combinational in the same cycle.
// Backpressure: on load-use, holds PC and IF/ID for one cycle and sends a bubble to EX.
// Ports: id_* decoded fields in, ex_* registered copies out, flush squashes the ID
//        instruction, pc_write/if_id_write/load_use_stall/stall_count report the stall.
module id_ex_hazard_stage #(
    parameter int DATA_W     = id_ex_hazard_stage_pkg::DATA_W,
    parameter int REG_ADDR_W = id_ex_hazard_stage_pkg::REG_ADDR_W,
    parameter int ALU_OP_W   = id_ex_hazard_stage_pkg::ALU_OP_W,
    parameter int CNT_W      = id_ex_hazard_stage_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_ctrl_reg_write,
    input  logic                  id_ctrl_mem_read,
    input  logic                  id_ctrl_mem_write,
    input  logic                  id_ctrl_mem_to_reg,
    input  logic                  id_ctrl_alu_src,
    input  logic                  id_ctrl_reg_dst,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [DATA_W-1:0]     id_pc4,
    input  logic                  flush,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_uses_rs,
    output logic                  ex_uses_rt,
    output logic                  ex_ctrl_reg_write,
    output logic                  ex_ctrl_mem_read,
    output logic                  ex_ctrl_mem_write,
    output logic                  ex_ctrl_mem_to_reg,
    output logic                  ex_ctrl_alu_src,
    output logic                  ex_ctrl_reg_dst,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [DATA_W-1:0]     ex_pc4,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  load_use_stall,
    output logic [CNT_W-1:0]      stall_count
);
    import id_ex_hazard_stage_pkg::*;

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  hz;

    assign id_ctrl = '{
        reg_write:  id_ctrl_reg_write,
        mem_read:   id_ctrl_mem_read,
        mem_write:  id_ctrl_mem_write,
        mem_to_reg: id_ctrl_mem_to_reg,
        alu_src:    id_ctrl_alu_src,
        reg_dst:    id_ctrl_reg_dst
    };

    load_use_detector #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_detector (
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .hz          (hz)
    );

    // Flush squashes the instruction being stalled, so there is nothing to hold for.
    assign load_use_stall = hz && !flush;
    assign pc_write       = !load_use_stall;
    assign if_id_write    = !load_use_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_uses_rs  <= 1'b0;
            ex_uses_rt  <= 1'b0;
            ex_ctrl     <= BUBBLE;
            ex_alu_op   <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_pc4      <= '0;
            stall_count <= '0;
        end else begin
            // Data fields are don't-care under a bubble, so they load unconditionally.
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_uses_rs <= id_uses_rs;
            ex_uses_rt <= id_uses_rt;
            ex_rd1     <= id_rd1;
            ex_rd2     <= id_rd2;
            ex_imm     <= id_imm;
            ex_pc4     <= id_pc4;
            if (flush || hz) begin
                ex_ctrl   <= BUBBLE;
                ex_alu_op <= '0;
            end else begin
                ex_ctrl   <= id_ctrl;
                ex_alu_op <= id_alu_op;
            end
            if (load_use_stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    assign ex_ctrl_reg_write  = ex_ctrl.reg_write;
    assign ex_ctrl_mem_read   = ex_ctrl.mem_read;
    assign ex_ctrl_mem_write  = ex_ctrl.mem_write;
    assign ex_ctrl_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_ctrl_alu_src    = ex_ctrl.alu_src;
    assign ex_ctrl_reg_dst    = ex_ctrl.reg_dst;

endmodule
